thor2025_regfile_lvt: RTL and testbench

Parametrised multi-write, multi-read register file for the Thor2025 core, built from one RAM bank per write port with a live value table (LVT) that selects the most recent writer per register. It replaces fixed-port register files with a single block configurable in data width, register count, write-port count and read-port count. It adds registered (one-cycle) reads, deterministic same-address write priority and a post-reset clear sequencer. It sits between the rename/commit stage (write side) and the operand-fetch stage (read side).

---
 rtl/thor2025_regfile_lvt.sv | 227 ++++++++++++++++++++++
 tb/tb_thor2025_regfile_lvt.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thor2025_regfile_lvt.sv
// thor2025_regfile_lvt -- multi-write / multi-read register file built from
// one RAM bank per write port and a live value table (LVT) that records which
// bank holds the newest copy of each register.
//
// Optional feature macro: THOR2025_REGFILE_BYPASS_EN
//   defined   : write-first reads (a read sampled alongside an accepted write
//               to the same nonzero address returns the new data)
//   undefined : read-first reads; no forwarding logic is generated
//
// Register 0 always reads as zero and is never written. After reset a clear
// sequencer zeroes every address through bank 0 while busy is high.

module thor2025_regfile_lvt #(
   parameter int WID  = 64,
   parameter int RBIT = 5,
   parameter int NWR  = 3,
   parameter int NRD  = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       busy,
   input  logic [NWR-1:0]             wr,
   input  logic [NWR*(RBIT+1)-1:0]    wa,
   input  logic [NWR*WID-1:0]         i,
   input  logic [NRD*(RBIT+1)-1:0]    ra,
   output logic [NRD*WID-1:0]         o
);

   localparam int AW   = RBIT + 1;
   localparam int NREG = 2 ** AW;
   localparam int LW   = (NWR > 1) ? $clog2(NWR) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_CLEAR,
      ST_RUN
   } state_t;

   state_t            state_q;
   logic [AW-1:0]     cnt_q;
   logic              busy_q;

   logic [AW-1:0]     wa_a   [NWR];
   logic [WID-1:0]    wd_a   [NWR];
   logic [AW-1:0]     ra_a   [NRD];
   logic [NWR-1:0]    acc;

   logic [NWR-1:0]    bank_we;
   logic [AW-1:0]     bank_wa [NWR];
   logic [WID-1:0]    bank_wd [NWR];

   logic [WID-1:0]    mem_q  [NWR][NRD][NREG];
   logic [WID-1:0]    rd_q   [NWR][NRD];
   logic [LW-1:0]     lvt_q  [NREG];
   logic [LW-1:0]     sel_q  [NRD];
   logic [NRD-1:0]    zero_q;

   assign busy = busy_q;

   // Split the flat port vectors into per-port fields.
   always_comb begin
      for (int k = 0; k < NWR; k++) begin
         wa_a[k] = wa[k*AW +: AW];
         wd_a[k] = i[k*WID +: WID];
      end
      for (int j = 0; j < NRD; j++) begin
         ra_a[j] = ra[j*AW +: AW];
      end
   end

   // A write is accepted only in normal operation and never to register 0.
   always_comb begin
      for (int k = 0; k < NWR; k++) begin
         acc[k] = wr[k] & rst_n & (state_q == ST_RUN) & (wa_a[k] != '0);
      end
   end

   // Bank write controls; the clear sequencer borrows bank 0's write port.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      for (int k = 0; k < NWR; k++) begin
         bank_we[k] = acc[k];
         bank_wa[k] = wa_a[k];
         bank_wd[k] = wd_a[k];
      end
      if (rst_n && state_q == ST_CLEAR) begin
         bank_we[0] = 1'b1;
         bank_wa[0] = cnt_q;
         bank_wd[0] = '0;
      end
   end

   // Clear sequencer: RESET -> CLEAR (one address per cycle) -> RUN.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_RESET: begin
               state_q <= ST_CLEAR;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
            ST_CLEAR: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               busy_q <= 1'b0;
            end
            default: begin
               state_q <= ST_RESET;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // RAM banks: one copy per read port, each written by its own write port.
   always_ff @(posedge clk) begin
      // NOTE: RAM contents are not reset; the clear sequencer and LVT give defined reads.
      for (int k = 0; k < NWR; k++) begin
         for (int j = 0; j < NRD; j++) begin
            if (bank_we[k]) begin
               mem_q[k][j][bank_wa[k]] <= bank_wd[k];
            end
            rd_q[k][j] <= mem_q[k][j][ra_a[j]];
         end
      end
   end

   // Live value table: the highest-index accepted writer owns the entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int a = 0; a < NREG; a++) begin
            lvt_q[a] <= '0;
         end
      end else begin
         // NOTE: later non-blocking assignments in the loop win, giving high-port priority.
         for (int k = 0; k < NWR; k++) begin
            if (acc[k]) begin
               lvt_q[wa_a[k]] <= LW'(k);
            end
         end
      end
   end

   // Capture bank select and zero-force alongside the registered RAM reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_q <= '1;
         for (int j = 0; j < NRD; j++) begin
            sel_q[j] <= '0;
         end
      end else begin
         for (int j = 0; j < NRD; j++) begin
            zero_q[j] <= busy_q | (ra_a[j] == '0);
            sel_q[j]  <= lvt_q[ra_a[j]];
         end
      end
   end

`ifdef THOR2025_REGFILE_BYPASS_EN
   logic [NRD-1:0]    byp_hit_d;
   logic [NRD-1:0]    byp_hit_q;
   logic [WID-1:0]    byp_dat_d [NRD];
   logic [WID-1:0]    byp_dat_q [NRD];

   // Find the highest-index accepted write that matches each read address.
   always_comb begin
      for (int j = 0; j < NRD; j++) begin
         byp_hit_d[j] = 1'b0;
         byp_dat_d[j] = '0;
         for (int k = 0; k < NWR; k++) begin
            if (acc[k] && wa_a[k] == ra_a[j]) begin
               byp_hit_d[j] = 1'b1;
               byp_dat_d[j] = wd_a[k];
            end
         end
      end
   end

   // Register the forwarded data alongside the RAM read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byp_hit_q <= '0;
         for (int j = 0; j < NRD; j++) begin
            byp_dat_q[j] <= '0;
         end
      end else begin
         byp_hit_q <= byp_hit_d;
         for (int j = 0; j < NRD; j++) begin
            byp_dat_q[j] <= byp_dat_d[j];
         end
      end
   end

   // Output select: zero-force, then forwarded data, then the LVT-chosen bank.
   always_comb begin
      o = '0;
      for (int j = 0; j < NRD; j++) begin
         if (!zero_q[j]) begin
            o[j*WID +: WID] = byp_hit_q[j] ? byp_dat_q[j] : rd_q[sel_q[j]][j];
         end
      end
   end
`else
   // Output select: zero-force, otherwise the LVT-chosen bank.
   always_comb begin
      o = '0;
      for (int j = 0; j < NRD; j++) begin
         if (!zero_q[j]) begin
            o[j*WID +: WID] = rd_q[sel_q[j]][j];
         end
      end
   end
`endif

endmodule

// File: tb/tb_thor2025_regfile_lvt.sv
// Testbench for thor2025_regfile_lvt: directed vectors, an architectural
// register model compared against every read port and busy on each cycle,
// plus hand-computed literal expectations.

module tb_thor2025_regfile_lvt;

   localparam int WID  = 64;
   localparam int RBIT = 5;
   localparam int AW   = RBIT + 1;
   localparam int NREG = 2 ** AW;
   localparam int NWR  = 3;
   localparam int NRD  = 10;

`ifdef THOR2025_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                    clk;
   logic                    rst_n;
   logic                    busy;
   logic [NWR-1:0]          wr;
   logic [NWR*AW-1:0]       wa;
   logic [NWR*WID-1:0]      wdata;
   logic [NRD*AW-1:0]       ra;
   logic [NRD*WID-1:0]      o;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   thor2025_regfile_lvt #(
      .WID(WID), .RBIT(RBIT), .NWR(NWR), .NRD(NRD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .busy(busy), .wr(wr), .wa(wa),
      .i(wdata), .ra(ra), .o(o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- architectural model ----------------
   // Registers hold their last accepted value; after any reset every register
   // is zero. busy lasts NREG+1 edges after release (one to leave reset, NREG
   // clear writes).
   logic [WID-1:0] model_reg [NREG];
   logic [WID-1:0] exp_o     [NRD];
   int             edges_since_rel = 0;
   bit             exp_busy = 1'b1;

   always @(posedge clk) begin
      bit busy_now;
      if (!rst_n) begin
         for (int a = 0; a < NREG; a++) model_reg[a] = '0;
         for (int j = 0; j < NRD; j++) exp_o[j] = '0;
         edges_since_rel = 0;
         exp_busy = 1'b1;
      end else begin
         busy_now = (edges_since_rel <= NREG);
         for (int j = 0; j < NRD; j++) begin
            int a;
            a = int'(ra[j*AW +: AW]);
            if (busy_now || a == 0) exp_o[j] = '0;
            else begin
               exp_o[j] = model_reg[a];
               if (BYP) begin
                  for (int k = 0; k < NWR; k++)
                     if (wr[k] && int'(wa[k*AW +: AW]) == a) exp_o[j] = wdata[k*WID +: WID];
               end
            end
         end
         if (!busy_now) begin
            for (int k = 0; k < NWR; k++)
               if (wr[k] && wa[k*AW +: AW] != 0) model_reg[wa[k*AW +: AW]] = wdata[k*WID +: WID];
         end
         if (edges_since_rel <= NREG) edges_since_rel++;
         exp_busy = (edges_since_rel <= NREG);
      end
   end

   // Compare process: every read port and busy, each cycle, away from the edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 64'(busy), 64'(exp_busy));
         for (int j = 0; j < NRD; j++)
            check($sformatf("o[%0d]", j), o[j*WID +: WID], exp_o[j]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_w(input int k, input logic en, input logic [AW-1:0] a, input logic [WID-1:0] d);
      wr[k] = en;
      wa[k*AW +: AW] = a;
      wdata[k*WID +: WID] = d;
   endtask

   task automatic set_r(input int j, input logic [AW-1:0] a);
      ra[j*AW +: AW] = a;
   endtask

   function automatic logic [WID-1:0] o_port(input int j);
      return o[j*WID +: WID];
   endfunction

   // Count negedge samples with busy=1, starting after the first edge post-release.
   task automatic measure_busy(output int n, input bit drop_write_at_2);
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         if (drop_write_at_2 && n == 2) wr = '0;
         n++;
         cyc();
      end
      if (n >= 300) check("busy_timeout", 64'(n), 64'(NREG));
   endtask

   int n_busy;

   initial begin
      rst_n = 1'b0;
      wr = '0; wa = '0; wdata = '0; ra = '0;
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      cyc(); cyc();
      check("reset_busy", 64'(busy), 64'd1);
      check("reset_o0", o_port(0), 64'd0);

      // Release reset; present a write during the clear sequence.
      rst_n = 1'b1;
      set_w(1, 1'b1, 6'd10, 64'hDEAD);
      cyc();
      measure_busy(n_busy, 1'b1);
      check("busy_cycles", 64'(n_busy), 64'(NREG));

      // Every register reads zero after the clear sequence.
      for (int b = 0; b < 7; b++) begin
         for (int j = 0; j < NRD; j++)
            set_r(j, AW'((b*NRD + j + 1 > NREG-1) ? NREG-1 : b*NRD + j + 1));
         cyc();
      end
      set_r(0, 6'd10);
      cyc();
      check("busy_write_dropped", o_port(0), 64'd0);

      // Basic multi-port write.
      set_w(0, 1'b1, 6'd5, 64'h11);
      set_w(1, 1'b1, 6'd6, 64'h22);
      set_w(2, 1'b1, 6'd7, 64'h33);
      cyc();
      wr = '0;
      set_r(0, 6'd5); set_r(4, 6'd6); set_r(9, 6'd7);
      cyc();
      check("mp_r5", o_port(0), 64'h11);
      check("mp_r6", o_port(4), 64'h22);
      check("mp_r7", o_port(9), 64'h33);

      // Same-address collision: highest port wins, then port 0 retakes r9.
      set_w(0, 1'b1, 6'd9, 64'hAAAA);
      set_w(2, 1'b1, 6'd9, 64'hBBBB);
      cyc();
      wr = '0;
      set_r(0, 6'd9);
      cyc();
      check("coll_r9", o_port(0), 64'hBBBB);
      set_w(0, 1'b1, 6'd9, 64'hCCCC);
      cyc();
      wr = '0;
      cyc();
      check("coll_r9_p0", o_port(0), 64'hCCCC);

      // Register 0 ignores writes.
      for (int j = 0; j < NRD; j++) set_r(j, 6'd0);
      set_w(1, 1'b1, 6'd0, 64'hFFFF);
      cyc();
      wr = '0;
      cyc();
      for (int j = 0; j < NRD; j++) check($sformatf("r0_port%0d", j), o_port(j), 64'd0);
      check("lvt_r0", 64'(dut.lvt_q[0]), 64'd0);

      // Read during write.
      set_w(0, 1'b1, 6'd12, 64'h1);
      cyc();
      wr = '0;
      set_w(1, 1'b1, 6'd12, 64'h2);
      set_r(0, 6'd12);
      cyc();
      wr = '0;
      check("rdw_same_cycle", o_port(0), BYP ? 64'h2 : 64'h1);
      cyc();
      check("rdw_next", o_port(0), 64'h2);

      // Reset in the middle of the clear sequence.
      set_w(2, 1'b1, 6'd3, 64'h55);
      cyc();
      wr = '0;
      set_r(0, 6'd3);
      cyc();
      check("pre_reset_r3", o_port(0), 64'h55);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      for (int c = 0; c < 20; c++) cyc();
      rst_n = 1'b0;
      cyc();
      check("midclear_busy", 64'(busy), 64'd1);
      rst_n = 1'b1;
      cyc();
      measure_busy(n_busy, 1'b0);
      check("restart_busy_cycles", 64'(n_busy), 64'(NREG));
      cyc();
      check("post_reset_r3", o_port(0), 64'd0);

      // A final mixed pattern across ports.
      set_w(0, 1'b1, 6'd63, 64'h0123_4567_89AB_CDEF);
      set_w(1, 1'b1, 6'd1,  64'hFEDC_BA98_7654_3210);
      set_w(2, 1'b0, 6'd2,  64'h9999);
      cyc();
      wr = '0;
      set_r(3, 6'd63); set_r(5, 6'd1); set_r(7, 6'd2);
      cyc();
      check("mix_r63", o_port(3), 64'h0123_4567_89AB_CDEF);
      check("mix_r1",  o_port(5), 64'hFEDC_BA98_7654_3210);
      check("mix_r2",  o_port(7), 64'd0);
      cyc();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
